// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder over an internal word-wide
// synchronous RAM. Loads and word stores take one access state; sub-word stores
// are done as read-modify-write. Done strobes for one cycle in RESP.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (adds the Misaligned output); otherwise low address bits are ignored.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        Misaligned
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } stateT;

  stateT       state;
  stateT       nextState;

  logic [AW+1:0] addrQ;
  logic [1:0]    byteSelQ;
  logic          unsignedQ;
  logic [31:0]   writeDataQ;
  logic [31:0]   oldWord;
  logic [31:0]   ramQ;
  logic [31:0]   ramWData;
  logic          ramWe;
  logic [31:0]   loadValue;
  logic [31:0]   mergedWord;
  logic [15:0]   loadHalf;
  logic [7:0]    loadByte;
  logic          accept;
  logic          isWordSel;
  logic          trap;
  logic          unusedAddrHi;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the word index alias onto the same RAM word.
  assign unusedAddrHi = ^Address[31:AW+2];

  assign isWordSel = (ByteSel == 2'b00) || (ByteSel == 2'b11);
  assign accept    = (state == IDLE) && Req && (MemRead || MemWrite);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic trapQ;

  // Misaligned halfword (odd address) or word (not 4-byte aligned) access.
  always_comb begin
    trap = 1'b0;
    if ((ByteSel == 2'b01) && Address[0])
      trap = 1'b1;
    else if (isWordSel && (Address[1:0] != 2'b00))
      trap = 1'b1;
  end

  // Remember whether the access heading into RESP was trapped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      trapQ <= 1'b0;
    else if (accept)
      trapQ <= trap;
  end

  assign Misaligned = (state == RESP) && trapQ;
`else
  assign trap = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Next-state decode, stall/strobe outputs and RAM write control.
  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    ramWe     = 1'b0;
    ramWData  = writeDataQ;
    case (state)
      IDLE: begin
        if (accept) begin
          Busy = 1'b1;
          if (trap)
            nextState = RESP;
          else if (MemWrite)
            nextState = isWordSel ? WRITE : RMW_READ;
          else
            nextState = READ;
        end
      end
      READ: begin
        Busy      = 1'b1;
        nextState = RESP;
      end
      WRITE: begin
        Busy      = 1'b1;
        ramWe     = 1'b1;
        nextState = RESP;
      end
      RMW_READ: begin
        Busy      = 1'b1;
        nextState = RMW_WRITE;
      end
      RMW_WRITE: begin
        Busy      = 1'b1;
        ramWe     = 1'b1;
        ramWData  = mergedWord;
        nextState = RESP;
      end
      RESP: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, RMW old-word capture and load result register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addrQ      <= '0;
      byteSelQ   <= '0;
      unsignedQ  <= 1'b0;
      writeDataQ <= '0;
      oldWord    <= '0;
      ReadData   <= '0;
    end else begin
      if (accept) begin
        addrQ      <= Address[AW+1:0];
        byteSelQ   <= ByteSel;
        unsignedQ  <= Unsigned;
        writeDataQ <= WriteData;
      end
      if (state == RMW_READ)
        oldWord <= ramQ;
      if (state == READ)
        ReadData <= loadValue;
    end
  end

  // RAM: read port follows the live request address while idle so the word
  // is ready in the first access state; contents are not reset.
  always_ff @(posedge Clock) begin
    if (ramWe)
      mem[addrQ[AW+1:2]] <= ramWData;
    if (state == IDLE)
      ramQ <= mem[Address[AW+1:2]];
  end

  // Lane select and sign/zero extension of the fetched word.
  always_comb begin
    loadHalf  = addrQ[1] ? ramQ[31:16] : ramQ[15:0];
    loadByte  = ramQ[{addrQ[1:0], 3'b000} +: 8];
    loadValue = ramQ;
    case (byteSelQ)
      2'b01:   loadValue = {{16{~unsignedQ & loadHalf[15]}}, loadHalf};
      2'b10:   loadValue = {{24{~unsignedQ & loadByte[7]}}, loadByte};
      default: loadValue = ramQ;
    endcase
  end

  // Replace only the addressed lane of the old word for sub-word stores.
  always_comb begin
    mergedWord = oldWord;
    case (byteSelQ)
      2'b01: begin
        if (addrQ[1])
          mergedWord[31:16] = writeDataQ[15:0];
        else
          mergedWord[15:0] = writeDataQ[15:0];
      end
      2'b10:   mergedWord[{addrQ[1:0], 3'b000} +: 8] = writeDataQ[7:0];
      default: mergedWord = writeDataQ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized accesses against a word-array
// reference model; a scoreboard queue holds expected responses, and a monitor
// checks each Done strobe for timing, ReadData and (when built) Misaligned.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  ByteSel;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        Misaligned;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ByteSel   (ByteSel),
    .Unsigned  (Unsigned),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Busy      (Busy),
    .Done      (Done)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .Misaligned(Misaligned)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  typedef struct {
    int          doneCyc;
    logic [31:0] rd;
    bit          trap;
  } expT;

  expT         sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] modelRd = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    expT e;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedDone: got Done=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("doneCycle", cyc, e.doneCyc);
        check("readData", ReadData, e.rd);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misaligned", {31'b0, Misaligned}, {31'b0, e.trap});
`endif
      end
    end
  end

  // Issue one request, update the model, queue the expectation, and watch
  // Busy until Done (bounded).
  task automatic issue(input bit rd, input bit wr, input logic [1:0] bs, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned w;
    int unsigned size;
    int unsigned sh;
    logic [31:0] mask;
    logic [31:0] v;
    bit          active;
    bit          trap;
    int          lat;
    int          busyCnt;
    int          k;
    int          maxK;
    bit          seen;
    expT         e;

    active = rd || wr;
    w      = (addr >> 2) % DEPTH;
    size   = (bs == 2'b01) ? 2 : (bs == 2'b10) ? 1 : 4;
    trap   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = active && (((size == 2) && addr[0]) || ((size == 4) && (addr[1:0] != 2'b00)));
`endif
    sh   = (size == 2) ? 16 * ((addr >> 1) & 1) : (size == 1) ? 8 * (addr & 3) : 0;
    mask = (size == 2) ? 32'h0000FFFF : (size == 1) ? 32'h000000FF : 32'hFFFFFFFF;
    lat  = trap ? 1 : (wr && size < 4) ? 3 : 2;

    if (active && !trap) begin
      if (wr) begin
        model[w] = (model[w] & ~(mask << sh)) | ((wdata & mask) << sh);
      end else begin
        v = (model[w] >> sh) & mask;
        if (!uns && size < 4 && v[8*size-1])
          v = v | ~mask;
        modelRd = v;
      end
    end

    @(negedge Clock);
    Req       = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    ByteSel   = bs;
    Unsigned  = uns;
    Address   = addr;
    WriteData = wdata;
    if (active) begin
      e.doneCyc = cyc + lat;
      e.rd      = modelRd;
      e.trap    = trap;
      sb.push_back(e);
    end

    busyCnt = 0;
    k       = 0;
    seen    = 1'b0;
    maxK    = active ? 8 : 3;
    #1;
    while (!seen && k < maxK) begin
      if (Done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (Busy === 1'b1) busyCnt++;
        @(negedge Clock);
        Req = 1'b0;
        #1;
        k++;
      end
    end
    Req = 1'b0;

    if (active) begin
      check("doneSeen", {31'b0, seen}, 32'd1);
      check("busyCycles", busyCnt, lat);
    end else begin
      check("noOpBusy", busyCnt, 0);
    end
  endtask

  logic [31:0] ra;

  initial begin
    Reset     = 1'b0;
    Req       = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ByteSel   = 2'b00;
    Unsigned  = 1'b0;
    Address   = '0;
    WriteData = '0;
    repeat (3) @(negedge Clock);
    check("resetReadData", ReadData, 32'h0);
    check("resetDone", {31'b0, Done}, 32'd0);
    check("resetBusy", {31'b0, Busy}, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("resetMisaligned", {31'b0, Misaligned}, 32'd0);
`endif
    Reset = 1'b1;

    // Initialise the working window (words 4..11) so every model word is known.
    for (int unsigned i = 4; i < 12; i++)
      issue(1'b0, 1'b1, 2'b00, 1'b0, i << 2, $urandom);

    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("planWordLoad", ReadData, 32'hDEADBEEF);

    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h000000A5);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("planByteMerge", ReadData, 32'hDEADA5EF);

    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    check("planByteSigned", ReadData, 32'hFFFFFFDE);
    issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
    check("planByteUnsigned", ReadData, 32'h000000DE);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("planHalfSigned", ReadData, 32'hFFFFDEAD);

    issue(1'b0, 1'b1, 2'b00, 1'b0, DEPTH * 4 + 32'h10, 32'h12345678);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("planWrap", ReadData, 32'h12345678);

    // Reset during RMW_READ of a byte store: store dropped, no Done.
    @(negedge Clock);
    Req       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    ByteSel   = 2'b10;
    Address   = 32'h10;
    WriteData = 32'h00000077;
    @(negedge Clock);
    Req = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    check("midResetDone", {31'b0, Done}, 32'd0);
    check("midResetBusy", {31'b0, Busy}, 32'd0);
    check("midResetReadData", ReadData, 32'h0);
    modelRd = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("postResetBusy", {31'b0, Busy}, 32'd0);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("planResetDropped", ReadData, 32'h12345678);

    // Misaligned word store.
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("planTrapUnchanged", ReadData, 32'h12345678);
`else
    check("planForcedAlign", ReadData, 32'hCAFEF00D);
`endif

    // Req without a command, and both commands together (store wins).
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h14, 32'h11111111);
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h14, 32'h55AA33CC);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
    check("planBothIsStore", ReadData, 32'h55AA33CC);

    // Randomized traffic over the window, with arbitrary aliasing high bits.
    for (int n = 0; n < 300; n++) begin
      int unsigned t;
      t  = $urandom_range(0, 9);
      ra = ($urandom_range(4, 11) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ra[31:12] = $urandom;
      if (t == 0)
        issue(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
      else if (t == 1)
        issue(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
      else if (t < 5)
        issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
      else
        issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
    end

    repeat (4) @(negedge Clock);
    check("scoreboardDrained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined CPU's MEM stage. It accepts load/store requests (MemRead, MemWrite, ByteSel, byte address, write data), executes them against an internal word-wide synchronous RAM, and returns load data with a one-cycle Done strobe. Sub-word stores are performed as read-modify-write. Busy stalls the pipeline while an access is in flight.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- AW, log2(DEPTH_WORDS): word-index width, derived.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  request valid; sampled only in IDLE.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; has priority over MemRead.
- ByteSel  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- Unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified for sub-word stores.
- ReadData  out  32  load result, held until the next load completes.
- Busy  out  1  pipeline stall request.
- Done  out  1  one-cycle completion strobe.
- Misaligned  out  1  alignment-error strobe; present only with the macro defined.

## Operation
- Little-endian: byte k of a word occupies bits [8k+7:8k]. Word index = Address[AW+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS.
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE with Req=1 latches Address, ByteSel, Unsigned and WriteData, then transitions:
  - store with ByteSel 00 or 11 -> WRITE
  - sub-word store -> RMW_READ
  - load -> READ
  - Req with neither MemRead nor MemWrite -> stays in IDLE, no Done.
- READ: RAM word arrives. The selected lane (Address[1:0] for byte, Address[1] for half) is extended and registered into ReadData. -> RESP.
- WRITE: full word is written. -> RESP.
- RMW_READ: old word is captured. -> RMW_WRITE.
- RMW_WRITE: only the target lane is replaced with WriteData[7:0] or WriteData[15:0], then the merged word is written. -> RESP.
- RESP: Done=1 for this cycle. -> IDLE.
- Busy = (IDLE & Req & (MemRead|MemWrite)) | state in {READ, WRITE, RMW_READ, RMW_WRITE}. Busy is low in RESP.
- Req asserted outside IDLE is ignored.
- RAM contents are not affected by reset.

## Timing
- Reset values: state IDLE, ReadData 0, Done 0, Busy 0, Misaligned 0.
- Request accepted at edge N (IDLE). Done cycle for each access type:
  - load: Done high in cycle N+2, with ReadData valid the same cycle
  - word store: Done in N+2
  - sub-word store: Done in N+3
- Back-to-back operation: a new Req may be accepted in the cycle after RESP (IDLE). The minimum issue interval is 3 cycles for loads and word stores, 4 for sub-word stores.
- Store-then-load to the same word returns the new data, since the write completes before RESP.
- Reset asserted mid-access: immediate return to IDLE, Done and Busy drop asynchronously. A store not yet in its WRITE/RMW_WRITE edge is dropped; a completed write persists.
- MemRead and MemWrite both high: executed as a store only.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a halfword with Address[0]=1, or a word with Address[1:0]!=0, is not executed.
  - IDLE goes directly to RESP.
  - Done=1 and Misaligned=1 for that one cycle.
  - RAM and ReadData are unchanged.
- DMEM_MISALIGN_TRAP_EN not defined: the Misaligned port is absent. Low address bits are forced aligned (Address[0] for halfword, Address[1:0] for word), and the access proceeds normally.

## Test plan
- Reset release, then store word 0xDEADBEEF at address 0x10, then load word from 0x10: Done 2 cycles after each Req, ReadData=0xDEADBEEF, Busy high for exactly 2 cycles per access.
- Store byte 0xA5 at 0x11, then load word from 0x10: ReadData=0xDEADA5EF; Busy high for 3 cycles on the store.
- Loads from 0x13: byte with Unsigned=0 gives 0xFFFFFFDE; byte with Unsigned=1 gives 0x000000DE; halfword at 0x12 with Unsigned=0 gives 0xFFFFDEAD.
- Wrap-around: store word 0x12345678 at address DEPTH_WORDS*4+0x10, then load word from 0x10: ReadData=0x12345678.
- Reset pulled low in the RMW_READ cycle of a byte store to 0x10: Done never asserts, state is IDLE after release, and a word load from 0x10 returns the pre-store value.
- With DMEM_MISALIGN_TRAP_EN: word store to 0x12 gives Done and Misaligned together one cycle after Req, and a word load from 0x10 is unchanged. Without the macro: the same store writes word 0x10.
